// File: rtl/fcmp_pipe.sv
// fcmp_pipe: pipelined floating-point compare (LT/LE/EQ/MIN/MAX) with valid/ready flow control
module fcmp_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 1,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] srca,
  input  logic [W-1:0] srcb,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         unord
);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} | (W'(1) << (MAN_W - 1));

  logic         w_za, w_zb, w_na, w_nb, w_nan, w_sa, w_sb;
  logic [W-2:0] w_ma, w_mb;
  logic         w_eq, w_lt, w_gt, w_bit;
  logic [W-1:0] w_min, w_max, w_res;
  logic [STAGES:0]   w_e;
  logic [STAGES-1:0] w_vin;
  logic [W:0]        w_din [STAGES];
  logic [STAGES-1:0] r_v;
  logic [W:0]        r_pl [STAGES];

  // classify operands (zero exponent flushes to zero, sign ignored) and build the result
  always_comb begin
    w_za  = srca[W-2:MAN_W] == '0;
    w_zb  = srcb[W-2:MAN_W] == '0;
    w_na  = &srca[W-2:MAN_W] && |srca[MAN_W-1:0];
    w_nb  = &srcb[W-2:MAN_W] && |srcb[MAN_W-1:0];
    w_nan = w_na || w_nb;
    w_sa  = srca[W-1];
    w_sb  = srcb[W-1];
    w_ma  = srca[W-2:0];
    w_mb  = srcb[W-2:0];
    w_eq  = (w_za && w_zb) || srca == srcb;
    w_lt  = (w_za && w_zb) ? 1'b0 :
            w_za           ? !w_sb :
            w_zb           ? w_sa :
            w_sa != w_sb   ? w_sa :
            w_sa           ? w_ma > w_mb : w_ma < w_mb;
    w_gt  = !w_lt && !w_eq;
    w_min = (w_na && w_nb) ? QNAN : w_na ? srcb : w_nb ? srca : w_gt ? srcb : srca;
    w_max = (w_na && w_nb) ? QNAN : w_na ? srcb : w_nb ? srca : w_lt ? srcb : srca;
    w_bit = op == 3'd0 ? w_lt : op == 3'd1 ? (w_lt || w_eq) : w_eq;
    w_res = op <= 3'd2 ? {{(W-1){1'b0}}, !w_nan && w_bit} :
            op == 3'd3 ? w_min :
            op == 3'd4 ? w_max : '0;
  end

  // stage advance enables ripple back from out_ready; each stage's input comes from its upstream
  always_comb begin
    w_e[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) w_e[k] = !r_v[k] || w_e[k+1];
    w_vin[0] = in_valid;
    w_din[0] = {w_nan, w_res};
    for (int k = 1; k < STAGES; k++) begin
      w_vin[k] = r_v[k-1];
      w_din[k] = r_pl[k-1];
    end
  end

  // pipeline registers; payload only loads with a valid beat so it reads 0 until the first result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) r_pl[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_e[k]) begin
          r_v[k] <= w_vin[k];
          if (w_vin[k]) r_pl[k] <= w_din[k];
        end
      end
    end
  end

  assign in_ready        = w_e[0];
  assign out_valid       = r_v[STAGES-1];
  assign {unord, result} = r_pl[STAGES-1];
endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: scoreboard bench for fcmp_pipe at STAGES=1 and STAGES=3
module tb_fcmp_pipe;
  logic clk = 0, rstn = 0;
  logic iv1 = 0, iv3 = 0, or1 = 1, or3 = 1;
  logic [2:0] op = 0;
  logic [31:0] sa = 0, sb = 0;
  logic [32:0] e1 = 0, e3 = 0;
  logic ir1, ov1, un1, ir3, ov3, un3;
  logic [31:0] res1, res3;
  int n_vec = 0, n_err = 0, sent = 0;
  logic [32:0] q1[$], q3[$];
  logic stall3 = 0;
  logic [32:0] held3 = 0, want;

  always #5 clk = ~clk;

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(1)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(iv1), .in_ready(ir1), .srca(sa), .srcb(sb), .op(op),
    .out_valid(ov1), .out_ready(or1), .result(res1), .unord(un1));

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(3)) u3 (
    .clk(clk), .rstn(rstn), .in_valid(iv3), .in_ready(ir3), .srca(sa), .srcb(sb), .op(op),
    .out_valid(ov3), .out_ready(or3), .result(res3), .unord(un3));

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // scoreboard: push expected on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (!rstn) stall3 = 0;
    else begin
      if (ov1 && or1) begin
        want = q1.size() != 0 ? q1.pop_front() : 33'bx;
        chk("sb1", {un1, res1}, want);
      end
      if (iv1 && ir1) q1.push_back(e1);
      chk1("ready3", ir3, (q3.size() < 3) || or3);
      if (stall3) begin
        chk1("hold_v3", ov3, 1'b1);
        chk("hold_d3", {un3, res3}, held3);
      end
      stall3 = ov3 && !or3;
      held3  = {un3, res3};
      if (ov3 && or3) begin
        want = q3.size() != 0 ? q3.pop_front() : 33'bx;
        chk("sb3", {un3, res3}, want);
      end
      if (iv3 && ir3) q3.push_back(e3);
    end
  end

  task automatic send1(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [32:0] e);
    op = o; sa = a; sb = b; e1 = e; iv1 = 1;
    @(posedge clk); #1 iv1 = 0;
    chk1("lat1", ov1, 1'b1);
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL timeout");
  end

  initial begin
    #1;
    chk1("rst_ov1", ov1, 1'b0);
    chk("rst_pl1", {un1, res1}, 33'h0);
    chk1("rst_ir1", ir1, 1'b1);
    chk1("rst_ov3", ov3, 1'b0);
    chk("rst_pl3", {un3, res3}, 33'h0);
    chk1("rst_ir3", ir3, 1'b1);
    @(posedge clk); @(posedge clk); #1 rstn = 1;
    @(posedge clk); #1;
    chk1("post_rst_ir3", ir3, 1'b1);
    chk("post_rst_pl3", {un3, res3}, 33'h0);
    // functional vectors, STAGES=1
    send1(3'd0, 32'h3F800000, 32'h40000000, {1'b0, 32'h1});
    send1(3'd0, 32'h40000000, 32'h3F800000, {1'b0, 32'h0});
    send1(3'd0, 32'hC0000000, 32'hBF800000, {1'b0, 32'h1});
    send1(3'd2, 32'h80000000, 32'h00000000, {1'b0, 32'h1});
    send1(3'd0, 32'h80000000, 32'h00000000, {1'b0, 32'h0});
    send1(3'd2, 32'h00000001, 32'h00000000, {1'b0, 32'h1});
    send1(3'd1, 32'hFF800000, 32'h00000000, {1'b0, 32'h1});
    send1(3'd0, 32'h7FC00000, 32'h3F800000, {1'b1, 32'h0});
    send1(3'd4, 32'h7FC00000, 32'h3F800000, {1'b1, 32'h3F800000});
    send1(3'd3, 32'h7FC00001, 32'hFFC00000, {1'b1, 32'h7FC00000});
    send1(3'd3, 32'h80000000, 32'h00000000, {1'b0, 32'h80000000});
    send1(3'd4, 32'h80000000, 32'h00000000, {1'b0, 32'h80000000});
    send1(3'd3, 32'hBF800000, 32'h3F800000, {1'b0, 32'hBF800000});
    send1(3'd4, 32'hBF800000, 32'h3F800000, {1'b0, 32'h3F800000});
    send1(3'd5, 32'h7FC00000, 32'h00000000, {1'b1, 32'h0});
    send1(3'd7, 32'h3F800000, 32'h40000000, {1'b0, 32'h0});
    send1(3'd1, 32'h40000000, 32'h40000000, {1'b0, 32'h1});
    send1(3'd0, 32'h40000000, 32'h40000000, {1'b0, 32'h0});
    send1(3'd2, 32'h3F800000, 32'h3F800001, {1'b0, 32'h0});
    send1(3'd0, 32'h7F800000, 32'h7F7FFFFF, {1'b0, 32'h0});
    send1(3'd0, 32'h7F7FFFFF, 32'h7F800000, {1'b0, 32'h1});
    send1(3'd3, 32'hC0000000, 32'h80000001, {1'b0, 32'hC0000000});
    send1(3'd0, 32'h00000000, 32'hBF800000, {1'b0, 32'h0});
    send1(3'd2, 32'h7FC00000, 32'h7FC00000, {1'b1, 32'h0});
    send1(3'd4, 32'hFFC00000, 32'h7F800000, {1'b1, 32'h7F800000});
    send1(3'd1, 32'h80000000, 32'h80000001, {1'b0, 32'h1});
    @(posedge clk); #1;
    chk("q1_empty", 33'(q1.size()), 33'h0);
    // backpressure, STAGES=3: out_ready low for cycles 2..6
    sent = 0;
    for (int c = 1; c <= 14; c++) begin
      or3 = !(c >= 2 && c <= 6);
      iv3 = sent < 6;
      if (sent < 6) begin
        op = 3'd4; sa = 32'h3F800000 + 32'(sent); sb = 32'h3F800000; e3 = {1'b0, sa};
      end
      @(negedge clk);
      if (iv3 && ir3) sent++;
      @(posedge clk); #1;
    end
    iv3 = 0;
    chk("bp_sent", 33'(sent), 33'd6);
    chk("bp_drain", 33'(q3.size()), 33'h0);
    // bubble collapse: beat, two idle cycles, two beats, all while stalled
    for (int c = 0; c <= 11; c++) begin
      iv3 = (c == 0 || c == 3 || c == 4);
      or3 = c >= 8;
      op = 3'd3; sa = 32'hC0000000 + 32'(c); sb = 32'h40000000; e3 = {1'b0, sa};
      @(negedge clk);
      if (iv3) chk1("bub_acc", ir3, 1'b1);
      @(posedge clk); #1;
    end
    iv3 = 0;
    chk("bub_drain", 33'(q3.size()), 33'h0);
    // reset with two beats in flight
    or3 = 1;
    op = 3'd0; sa = 32'h3F800000; sb = 32'h40000000; e3 = {1'b0, 32'h1}; iv3 = 1;
    @(posedge clk); #1;
    sa = 32'h40000000; sb = 32'h3F800000; e3 = {1'b0, 32'h0};
    @(posedge clk); #1 iv3 = 0;
    chk1("inflight_v", ov3, 1'b0);
    #2 rstn = 0;
    #1;
    chk1("arst_ov3", ov3, 1'b0);
    chk("arst_pl3", {un3, res3}, 33'h0);
    chk1("arst_ir3", ir3, 1'b1);
    q1.delete(); q3.delete();
    @(negedge clk); #2 rstn = 1;
    @(posedge clk); #1;
    chk1("rel_ir3", ir3, 1'b1);
    op = 3'd4; sa = 32'h40400000; sb = 32'h3F800000; e3 = {1'b0, 32'h40400000}; iv3 = 1;
    @(posedge clk); #1 iv3 = 0;
    chk1("lat3_c1", ov3, 1'b0);
    @(posedge clk); #1;
    chk1("lat3_c2", ov3, 1'b0);
    @(posedge clk); #1;
    chk1("lat3_c3", ov3, 1'b1);
    @(posedge clk); #1;
    chk("rst_drain", 33'(q3.size()), 33'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
